vit_host_loader: RTL and testbench
==================================

# vit_host_loader

Streaming front-end that fills the accelerator's word-addressed staging registers and commits them into the weight memories. It accepts a command (target memory select, base row, row count) and then a stream of DATA_WIDTH words. It drives `data_in`/`wrd_addr`/`mem_sel` one word per cycle and pulses `mem_en`/`mem_wr` per completed row. It sits directly upstream of the top-level accelerator and replaces hand-driven host pins.

## Interface
Parameters:
- DATA_WIDTH, 4, word width
- MAX_ADDR_W, 8, memory row address width
- WORD_ADDR_W, 13, staging word index width; must satisfy 2^WORD_ADDR_W − 1 ≥ max(X_WORDS, W_WORDS)
- X_WORDS, 768, words per X vector (X_IN)
- W_WORDS, 5625, words per weight row (W_WIDTH / DATA_WIDTH)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  loader idle, command accepted on valid&ready
- cmd_sel  in  3  target memory; 3'd6 = X vector, others = weight memory
- cmd_base  in  MAX_ADDR_W  first row address
- cmd_rows  in  MAX_ADDR_W+1  rows to load (ignored for sel 6)
- s_valid  in  1  stream word valid
- s_ready  out  1  stream word accepted on valid&ready
- s_data  in  DATA_WIDTH  stream word
- data_in  out  DATA_WIDTH  staging write data
- wrd_addr  out  WORD_ADDR_W  staging word index
- mem_sel  out  3  memory select
- mem_addr  out  MAX_ADDR_W  row address for commit
- mem_en, mem_wr  out  1 each  commit strobe
- input_rdy  in  1  accelerator ready for new X
- start  out  1  accelerator start pulse
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion

## Operation
- All outputs are registered.
- Reset values: cmd_ready=1, s_ready=0, data_in=0, wrd_addr=all-ones, mem_sel=0, mem_addr=0, mem_en=0, mem_wr=0, start=0, busy=0, done=0.
- Whenever no word is being written, wrd_addr is all-ones (out of range), so the staging registers are never corrupted.
- States:
  - IDLE: on cmd_valid, latch sel, base, and rows; set row=0 and word=0. If sel≠6 and rows=0, pulse done and stay in IDLE. Otherwise go to FILL.
  - FILL: s_ready=1. On each accepted word, next cycle data_in=s_data and wrd_addr=word; word increments. When a gap occurs (no accept), wrd_addr returns to all-ones. After the last word (word = N−1, where N = X_WORDS for sel 6, else W_WORDS), go to FLUSH.
  - FLUSH: 1 cycle, s_ready=0. Lets the final staging write settle.
  - COMMIT (sel≠6): mem_en=mem_wr=1 for exactly one cycle with mem_addr=base+row (mod 2^MAX_ADDR_W).
    - Then row increments.
    - If row < rows, return to FILL with word=0.
    - Otherwise pulse done and return to IDLE.
  - For sel 6, FLUSH goes to LAUNCH (see Configuration), or else pulses done and returns to IDLE.
- busy=1 in every state except IDLE. cmd_ready = ~busy.
- mem_sel is driven from the latched sel from command accept until the next command.
- Reset mid-command aborts immediately; no commit is issued.

## Timing
- Word accepted at cycle t → visible on data_in/wrd_addr in t+1.
- Last word accepted at t → FLUSH at t+1, COMMIT at t+2, next row's s_ready at t+3.
- Throughput: N+2 cycles per row with no backpressure.
- done pulses in the cycle after COMMIT (or after FLUSH/LAUNCH) and coincides with cmd_ready rising.
- cmd_valid while busy is ignored.

## Configuration
- LOADER_AUTOSTART_EN defined: after an X load, state LAUNCH waits for input_rdy=1, then pulses start for one cycle, then pulses done the next cycle.
- Not defined: start is tied to 0, LAUNCH does not exist, and the X load completes after FLUSH.

## Structure
- Package vit_loader_pkg holds:
  - the state enum (IDLE, FILL, FLUSH, COMMIT, LAUNCH)
  - MEM_SEL_X = 3'd6
  - a function giving the word count per select
- Single module; no sub-module is warranted.

## Test plan
- Reset values: assert rst mid-cycle → all outputs at reset values asynchronously; wrd_addr=all-ones.
- Weight load with W_WORDS=8, cmd_sel=1, base=5, rows=2, continuous stream 0..15:
  - wrd_addr sequences 0..7 twice.
  - mem_en pulses with mem_addr=5, then 6, each two cycles after the last word.
  - done follows.
- Backpressure: s_valid toggles 1/0 → no word is skipped, wrd_addr=all-ones on gap cycles, commit count unchanged.
- X load with autostart, X_WORDS=4, input_rdy held 0 for 10 cycles then 1 → start pulses once, in the cycle after input_rdy rises; done follows one cycle later.
- cmd_rows=0 with sel=2 → done in the cycle after accept, no mem_en, s_ready never high.
- Reset during row 1 of 2 → no second commit, cmd_ready=1 after reset, a new command runs normally.

Source files
------------

// File: rtl/vit_loader_pkg.sv
// Shared types and helpers for the host-side weight/X loader.
// Word counts are passed in so the package stays independent of any one instance's parameters.
package vit_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      FLUSH,
      COMMIT,
      LAUNCH
   } state_t;

   localparam logic [2:0] MEM_SEL_X = 3'd6;

   function automatic int unsigned words_for_sel(input logic [2:0] sel,
                                                 input int unsigned x_words,
                                                 input int unsigned w_words);
      return (sel == MEM_SEL_X) ? x_words : w_words;
   endfunction

endpackage

// File: rtl/vit_host_loader.sv
// Streams host words into the accelerator staging registers and commits full rows to weight memory.
// Optional LOADER_AUTOSTART_EN: after an X load, wait for input_rdy and pulse start before done.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// FILL   | accepting stream words into staging registers
// FLUSH  | one cycle for the final staging write to land
// COMMIT | mem_en/mem_wr strobe for the current row
// LAUNCH | X loaded, waiting for input_rdy to pulse start
module vit_host_loader
   import vit_loader_pkg::*;
#(
   parameter int DATA_WIDTH  = 4,
   parameter int MAX_ADDR_W  = 8,
   parameter int WORD_ADDR_W = 13,
   parameter int X_WORDS     = 768,
   parameter int W_WORDS     = 5625
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [2:0]             cmd_sel,
   input  logic [MAX_ADDR_W-1:0]  cmd_base,
   input  logic [MAX_ADDR_W:0]    cmd_rows,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [DATA_WIDTH-1:0]  s_data,
   output logic [DATA_WIDTH-1:0]  data_in,
   output logic [WORD_ADDR_W-1:0] wrd_addr,
   output logic [2:0]             mem_sel,
   output logic [MAX_ADDR_W-1:0]  mem_addr,
   output logic                   mem_en,
   output logic                   mem_wr,
   input  logic                   input_rdy,
   output logic                   start,
   output logic                   busy,
   output logic                   done
);

   localparam logic [MAX_ADDR_W:0] ROW_ONE = 1;

   state_t                  state, state_nxt;
   logic [2:0]              sel_q;
   logic [MAX_ADDR_W-1:0]   base_q;
   logic [MAX_ADDR_W:0]     rows_q, row_q;
   logic [WORD_ADDR_W-1:0]  word_q, last_word;
   logic                    cmd_acc, cmd_empty, word_acc, last_acc, is_x, row_more;
   logic                    s_ready_d, busy_d, mem_en_d, done_d;
   logic [WORD_ADDR_W-1:0]  wrd_addr_d;

   assign cmd_acc   = (state == IDLE) && cmd_valid;
   assign cmd_empty = (cmd_sel != MEM_SEL_X) && (cmd_rows == '0);
   assign word_acc  = s_valid && s_ready;
   assign last_word = WORD_ADDR_W'(words_for_sel(sel_q, X_WORDS, W_WORDS) - 1);
   assign last_acc  = word_acc && (word_q == last_word);
   assign is_x      = (sel_q == MEM_SEL_X);
   assign row_more  = (row_q + ROW_ONE) < rows_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (cmd_valid && !cmd_empty) state_nxt = FILL;
         FILL:   if (last_acc) state_nxt = FLUSH;
         FLUSH: begin
            if (!is_x) state_nxt = COMMIT;
`ifdef LOADER_AUTOSTART_EN
            else       state_nxt = LAUNCH;
`else
            else       state_nxt = IDLE;
`endif
         end
         COMMIT: state_nxt = row_more ? FILL : IDLE;
         LAUNCH: if (start) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are registered, so they are decoded from the state being entered.
   always_comb begin
      s_ready_d  = (state_nxt == FILL);
      busy_d     = (state_nxt != IDLE);
      mem_en_d   = (state_nxt == COMMIT);
      done_d     = (cmd_acc && cmd_empty) || ((state != IDLE) && (state_nxt == IDLE));
      wrd_addr_d = word_acc ? word_q : '1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_ready <= 1'b1;
         s_ready   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_en    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_sel   <= '0;
         data_in   <= '0;
         wrd_addr  <= '1;
         sel_q     <= '0;
         base_q    <= '0;
         rows_q    <= '0;
         row_q     <= '0;
         word_q    <= '0;
      end else begin
         cmd_ready <= ~busy_d;
         s_ready   <= s_ready_d;
         busy      <= busy_d;
         done      <= done_d;
         mem_en    <= mem_en_d;
         mem_wr    <= mem_en_d;
         wrd_addr  <= wrd_addr_d;
         if (word_acc) begin
            data_in <= s_data;
            word_q  <= last_acc ? '0 : word_q + 1'b1;
         end
         if (cmd_acc) begin
            sel_q   <= cmd_sel;
            mem_sel <= cmd_sel;
            base_q  <= cmd_base;
            rows_q  <= cmd_rows;
            row_q   <= '0;
            word_q  <= '0;
         end
         if (mem_en_d) mem_addr <= base_q + row_q[MAX_ADDR_W-1:0];
         if (state == COMMIT) row_q <= row_q + ROW_ONE;
      end
   end

`ifdef LOADER_AUTOSTART_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) start <= 1'b0;
      else     start <= (state == LAUNCH) && input_rdy && !start;
   end
`else
   wire unused_input_rdy = input_rdy;
   assign start = 1'b0;
`endif

endmodule

// File: tb/tb_vit_host_loader.sv
// Randomized self-checking bench for vit_host_loader with a cycle-level event model.
// Follows LOADER_AUTOSTART_EN the same way the design does.
module tb_vit_host_loader;
   import vit_loader_pkg::*;

   localparam int XW = 4;
   localparam int WW = 8;

   logic        clk = 0, rst = 0;
   logic        cmd_valid = 0, cmd_ready;
   logic [2:0]  cmd_sel = 0;
   logic [7:0]  cmd_base = 0;
   logic [8:0]  cmd_rows = 0;
   logic        s_valid = 0, s_ready;
   logic [3:0]  s_data = 0;
   logic [3:0]  data_in;
   logic [12:0] wrd_addr;
   logic [2:0]  mem_sel;
   logic [7:0]  mem_addr;
   logic        mem_en, mem_wr;
   logic        input_rdy = 0;
   logic        start, busy, done;

   vit_host_loader #(.DATA_WIDTH(4), .MAX_ADDR_W(8), .WORD_ADDR_W(13),
                     .X_WORDS(XW), .W_WORDS(WW)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_sel(cmd_sel), .cmd_base(cmd_base), .cmd_rows(cmd_rows),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .data_in(data_in), .wrd_addr(wrd_addr), .mem_sel(mem_sel), .mem_addr(mem_addr),
      .mem_en(mem_en), .mem_wr(mem_wr), .input_rdy(input_rdy), .start(start),
      .busy(busy), .done(done));

   always #5 clk = ~clk;

   int n_checks = 0, n_errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference model: tracks what the outputs must show, derived from accepted commands/words.
   bit  mon_on = 0;
   bit  pend = 0;
   int  pend_idx, acc, m_n = WW, m_rows, m_base, m_commits;
   logic [2:0] m_sel;
   logic [3:0] pend_data;
   int  commit_due = -1, done_due = -1, start_due = -1, launch_at = 0;
   bit  launch_pend = 0;
   int  n_commits = 0, n_starts = 0, n_sready = 0;

   always @(negedge clk) begin
      if (rst) begin
         pend = 0; commit_due = -1; done_due = -1; start_due = -1; launch_pend = 0;
      end else if (mon_on) begin
         chk("wrd_addr", 32'(wrd_addr), pend ? 32'(pend_idx) : 32'(13'h1fff));
         if (pend) chk("data_in", 32'(data_in), 32'(pend_data));
         chk("mem_en", 32'(mem_en), 32'(cyc == commit_due));
         chk("done", 32'(done), 32'(cyc == done_due));
         chk("start", 32'(start), 32'(cyc == start_due));
         chk("cmd_ready", 32'(cmd_ready), 32'(!busy));
         if (mem_en) begin
            chk("mem_wr", 32'(mem_wr), 32'(1));
            chk("mem_addr", 32'(mem_addr), 32'((m_base + m_commits) % 256));
            chk("mem_sel", 32'(mem_sel), 32'(m_sel));
            m_commits++; n_commits++;
         end
         if (start) n_starts++;
         if (s_ready) n_sready++;
         if (cmd_valid && cmd_ready) begin
            m_sel = cmd_sel; m_base = int'(cmd_base); m_rows = int'(cmd_rows);
            m_n = (cmd_sel == 3'd6) ? XW : WW;
            acc = 0; m_commits = 0;
            if (cmd_sel != 3'd6 && cmd_rows == 0) done_due = cyc + 1;
         end
`ifdef LOADER_AUTOSTART_EN
         if (launch_pend && cyc >= launch_at && input_rdy) begin
            start_due = cyc + 1; done_due = cyc + 2; launch_pend = 0;
         end
`endif
         pend = s_valid && s_ready;
         if (pend) begin
            pend_idx = acc % m_n; pend_data = s_data; acc++;
            if (acc % m_n == 0) begin
               if (m_sel != 3'd6) begin
                  commit_due = cyc + 2;
                  if (acc / m_n == m_rows) done_due = cyc + 3;
               end else begin
`ifdef LOADER_AUTOSTART_EN
                  launch_pend = 1; launch_at = cyc + 2;
`else
                  done_due = cyc + 2;
`endif
               end
            end
         end
      end
   end

   task automatic check_reset_vals();
      chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
      chk("rst_s_ready", 32'(s_ready), 32'(0));
      chk("rst_data_in", 32'(data_in), 32'(0));
      chk("rst_wrd_addr", 32'(wrd_addr), 32'(13'h1fff));
      chk("rst_mem_sel", 32'(mem_sel), 32'(0));
      chk("rst_mem_addr", 32'(mem_addr), 32'(0));
      chk("rst_mem_en", 32'(mem_en), 32'(0));
      chk("rst_mem_wr", 32'(mem_wr), 32'(0));
      chk("rst_start", 32'(start), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
   endtask

   task automatic issue_cmd(input logic [2:0] sel, input logic [7:0] base, input logic [8:0] rows);
      cmd_sel = sel; cmd_base = base; cmd_rows = rows; cmd_valid = 1;
      @(posedge clk); #1;
      cmd_valid = 0;
   endtask

   // mode 0: continuous counting data, 1: valid toggles, 2: random valid
   task automatic stream(input int total, input int mode);
      int sent = 0;
      int guard = 0;
      logic [3:0] d = 0;
      while (sent < total && guard < 2000) begin
         s_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ~guard[0] : 1'($urandom_range(0, 1));
         d = (mode == 0) ? 4'(sent) : d;
         s_data = d;
         @(negedge clk);
         if (s_valid && s_ready) begin
            sent++;
            d = 4'($urandom);
         end
         @(posedge clk); #1;
         guard++;
      end
      s_valid = 0;
      if (sent < total) chk("stream_timeout", 32'(sent), 32'(total));
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin @(negedge clk); n++; end while (busy && n < 500);
      if (busy) chk("idle_timeout", 32'(busy), 32'(0));
      @(posedge clk); #1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   int c0, s0, st0, rows_r, mode_r;
   logic [2:0] sel_r;

   initial begin
      // reset asserted mid-cycle must clear outputs without a clock edge
      repeat (2) @(posedge clk);
      #3 rst = 1;
      #1 check_reset_vals();
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 0;
      @(posedge clk); #1;
      mon_on = 1;

      // weight load, base 5, two rows, continuous 0..15; busy-time commands must be ignored
      c0 = n_commits;
      issue_cmd(3'd1, 8'd5, 9'd2);
      cmd_valid = 1; cmd_sel = 3'd2; cmd_base = 8'd77; cmd_rows = 9'd1;
      stream(16, 0);
      cmd_valid = 0;
      wait_idle();
      chk("w_commits", 32'(n_commits - c0), 32'(2));

      // backpressure with row address wrap
      c0 = n_commits;
      issue_cmd(3'd3, 8'd255, 9'd2);
      stream(16, 1);
      wait_idle();
      chk("bp_commits", 32'(n_commits - c0), 32'(2));

      // X load; input_rdy held low for a while
      c0 = n_commits; st0 = n_starts;
      input_rdy = 0;
      issue_cmd(3'd6, 8'd0, 9'd0);
      stream(XW, 0);
      repeat (10) @(posedge clk);
      #1 input_rdy = 1;
      wait_idle();
      input_rdy = 0;
`ifdef LOADER_AUTOSTART_EN
      chk("x_starts", 32'(n_starts - st0), 32'(1));
`else
      chk("x_starts", 32'(n_starts - st0), 32'(0));
`endif
      chk("x_commits", 32'(n_commits - c0), 32'(0));

      // zero-row weight command
      c0 = n_commits; s0 = n_sready;
      issue_cmd(3'd2, 8'd7, 9'd0);
      repeat (4) @(posedge clk);
      #1;
      chk("z_sready", 32'(n_sready - s0), 32'(0));
      chk("z_commits", 32'(n_commits - c0), 32'(0));
      chk("z_cmd_ready", 32'(cmd_ready), 32'(1));

      // reset during row 1 of 2
      c0 = n_commits;
      issue_cmd(3'd1, 8'd9, 9'd2);
      stream(WW + 3, 0);
      mon_on = 0;
      #3 rst = 1;
      #1 check_reset_vals();
      @(negedge clk) rst = 0;
      @(posedge clk); #1;
      mon_on = 1;
      repeat (15) @(posedge clk);
      #1;
      chk("rst_mid_commits", 32'(n_commits - c0), 32'(1));
      chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'(1));
      c0 = n_commits;
      issue_cmd(3'd4, 8'd100, 9'd1);
      stream(WW, 2);
      wait_idle();
      chk("after_rst_commits", 32'(n_commits - c0), 32'(1));

      // randomized commands
      input_rdy = 1;
      for (int i = 0; i < 6; i++) begin
         sel_r  = 3'($urandom_range(0, 6));
         rows_r = $urandom_range(1, 3);
         mode_r = $urandom_range(0, 2);
         c0 = n_commits;
         issue_cmd(sel_r, 8'($urandom), 9'(rows_r));
         stream((sel_r == 3'd6) ? XW : rows_r * WW, mode_r);
         wait_idle();
         chk("rnd_commits", 32'(n_commits - c0), (sel_r == 3'd6) ? 32'(0) : 32'(rows_r));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
